// File: rtl/ddr3_dma_pkg.sv
// Shared widths, packing ratio and FSM encoding for the DDR3 DMA write packer.
package ddr3_dma_pkg;
   localparam int DMA_ADDR_WIDTH = 27;
   localparam int IN_WIDTH       = 64;
   localparam int OUT_WIDTH      = 512;
   localparam int RATIO          = OUT_WIDTH / IN_WIDTH;
   localparam int LANE_W         = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam bit WIDTH_OK       = ((OUT_WIDTH % IN_WIDTH) == 0) && ((RATIO & (RATIO - 1)) == 0);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_STREAM    = 3'd2,
      ST_FLUSH     = 3'd3,
      ST_WAIT_DONE = 3'd4
   } state_t;
endpackage

// File: rtl/dma_word_packer.sv
// Packs IN_WIDTH beats into OUT_WIDTH words; a pack register feeds a single output register held under din_rdy.
module dma_word_packer
   import ddr3_dma_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 beat_valid,
   input  logic [IN_WIDTH-1:0]  beat_data,
   input  logic                 beat_final,
   input  logic                 din_rdy,
   output logic                 stall,
   output logic                 din_en,
   output logic [OUT_WIDTH-1:0] din,
   output logic                 din_eop
);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

   logic [LANE_W-1:0]    lane_cnt_r;
   logic [OUT_WIDTH-1:0] pack_r;
   logic [OUT_WIDTH-1:0] out_r;
   logic                 pack_full_r;
   logic                 pack_eop_r;
   logic                 out_valid_r;
   logic                 out_eop_r;
   logic [OUT_WIDTH-1:0] base_word_s;
   logic [OUT_WIDTH-1:0] wr_word_s;
   logic                 out_free_s;
   logic                 word_done_s;

   assign out_free_s  = !out_valid_r || din_rdy;
   assign word_done_s = beat_valid && (beat_final || (lane_cnt_r == LANE_LAST));
   assign stall       = pack_full_r && out_valid_r && !din_rdy;
   assign din_en      = out_valid_r && din_rdy;
   assign din_eop     = out_eop_r && din_en;
   assign din         = out_r;

   // Merge the beat into its lane; unwritten lanes stay zero, which gives the short-word zero fill.
   always_comb begin
      base_word_s = (pack_full_r && out_free_s) ? {OUT_WIDTH{1'b0}} : pack_r;
      wr_word_s   = base_word_s;
      if (beat_valid) begin
         wr_word_s[int'(lane_cnt_r) * IN_WIDTH +: IN_WIDTH] = beat_data;
      end else begin
         wr_word_s = base_word_s;
      end
   end

   // Lane counter, pack register and output register movement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_cnt_r  <= '0;
         pack_r      <= '0;
         out_r       <= '0;
         pack_full_r <= 1'b0;
         pack_eop_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_eop_r   <= 1'b0;
      end else if (clear) begin
         lane_cnt_r  <= '0;
         pack_r      <= '0;
         pack_full_r <= 1'b0;
         pack_eop_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_eop_r   <= 1'b0;
      end else begin
         if (beat_valid) begin
            lane_cnt_r <= word_done_s ? {LANE_W{1'b0}} : lane_cnt_r + 1'b1;
         end
         if (pack_full_r && out_free_s) begin
            out_r       <= pack_r;
            out_valid_r <= 1'b1;
            out_eop_r   <= pack_eop_r;
            pack_r      <= wr_word_s;
            pack_full_r <= word_done_s;
            pack_eop_r  <= word_done_s && beat_final;
         end else if (word_done_s && out_free_s) begin
            out_r       <= wr_word_s;
            out_valid_r <= 1'b1;
            out_eop_r   <= beat_final;
            pack_r      <= '0;
         end else if (word_done_s) begin
            pack_r      <= wr_word_s;
            pack_full_r <= 1'b1;
            pack_eop_r  <= beat_final;
         end else begin
            pack_r <= wr_word_s;
            if (din_en) begin
               out_valid_r <= 1'b0;
               out_eop_r   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/ddr3_dma_write_packer.sv
// DDR3 DMA write packer: command FSM, length bookkeeping and engine handshake around the word packer.
module ddr3_dma_write_packer
   import ddr3_dma_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [DMA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DMA_ADDR_WIDTH-1:0] cmd_words,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [IN_WIDTH-1:0]       s_data,
   input  logic                      s_last,
   output logic                      write_req,
   output logic [DMA_ADDR_WIDTH-1:0] write_start_addr,
   output logic [DMA_ADDR_WIDTH-1:0] write_length,
   input  logic                      write_done,
   input  logic                      din_rdy,
   output logic                      din_en,
   output logic [OUT_WIDTH-1:0]      din,
   output logic                      din_eop,
   output logic                      busy,
   output logic                      done,
   output logic                      len_err
);
   if (!WIDTH_OK) begin : g_width_check
      $error("OUT_WIDTH must be a power-of-two multiple of IN_WIDTH");
   end

   state_t                    state_r;
   state_t                    state_next_s;
   logic [DMA_ADDR_WIDTH-1:0] addr_r;
   logic [DMA_ADDR_WIDTH-1:0] len_r;
   logic [DMA_ADDR_WIDTH-1:0] remain_r;
   logic                      len_err_r;
   logic                      done_r;
   logic [DMA_ADDR_WIDTH:0]   len_calc_s;
   logic                      cmd_fire_s;
   logic                      beat_fire_s;
   logic                      final_beat_s;
   logic                      stall_s;

   assign len_calc_s   = ({1'b0, cmd_words} + (DMA_ADDR_WIDTH + 1)'(RATIO - 1))
                         / (DMA_ADDR_WIDTH + 1)'(RATIO);
   assign cmd_fire_s   = cmd_valid && (state_r == ST_IDLE);
   assign beat_fire_s  = s_valid && s_ready;
   assign final_beat_s = s_last || (remain_r == DMA_ADDR_WIDTH'(1'b1));

   assign write_start_addr = addr_r;
   assign write_length     = len_r;
   assign done             = done_r;
   assign len_err          = len_err_r;

   dma_word_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (cmd_fire_s),
      .beat_valid (beat_fire_s),
      .beat_data  (s_data),
      .beat_final (final_beat_s),
      .din_rdy    (din_rdy),
      .stall      (stall_s),
      .din_en     (din_en),
      .din        (din),
      .din_eop    (din_eop)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; a zero-beat command never leaves IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_next_s = (cmd_words == '0) ? ST_IDLE : ST_REQ;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_REQ:    state_next_s = ST_STREAM;
         ST_STREAM: begin
            if (beat_fire_s && final_beat_s) begin
               state_next_s = ST_FLUSH;
            end else begin
               state_next_s = ST_STREAM;
            end
         end
         ST_FLUSH: begin
            if (din_eop) begin
               state_next_s = ST_WAIT_DONE;
            end else begin
               state_next_s = ST_FLUSH;
            end
         end
         ST_WAIT_DONE: begin
            if (write_done) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State-decoded handshake outputs.
   always_comb begin
      cmd_ready = 1'b0;
      write_req = 1'b0;
      s_ready   = 1'b0;
      busy      = 1'b1;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_REQ:       write_req = 1'b1;
         ST_STREAM:    s_ready   = !stall_s;
         ST_FLUSH:     busy      = 1'b1;
         ST_WAIT_DONE: busy      = 1'b1;
         default:      busy      = 1'b1;
      endcase
   end

   // Command latch, beat countdown, length-error flag and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r    <= '0;
         len_r     <= '0;
         remain_r  <= '0;
         len_err_r <= 1'b0;
         done_r    <= 1'b0;
      end else if (cmd_fire_s) begin
         addr_r    <= cmd_addr;
         len_r     <= len_calc_s[DMA_ADDR_WIDTH-1:0];
         remain_r  <= cmd_words;
         len_err_r <= 1'b0;
         done_r    <= (cmd_words == '0);
      end else begin
         done_r <= (state_r == ST_WAIT_DONE) && write_done;
         if (beat_fire_s) begin
            remain_r <= remain_r - DMA_ADDR_WIDTH'(1'b1);
            if (final_beat_s && (s_last != (remain_r == DMA_ADDR_WIDTH'(1'b1)))) begin
               len_err_r <= 1'b1;
            end
         end
      end
   end
endmodule
